// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and helpers for the round-robin mux arbiter.
package rr_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        onehot_to_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) onehot_to_idx = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of (req & mask) searching
// from last+1 upward with wrap, so the index in 'last' is searched last.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    input  logic [NUM_REQ-1:0] mask,
    output logic               found,
    output logic [IDX_W-1:0]   win_idx
);

    logic [NUM_REQ-1:0] cand;

    assign cand = req & mask;

    // Walk offsets from farthest to nearest so the nearest candidate overwrites.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            if (cand[last + IDX_W'(k)]) begin
                found   = 1'b1;
                win_idx = last + IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter driving a shared 4:1 WIDTH-bit mux.
// Optional owner preemption after MAX_HOLD cycles: define ARB_TIMEOUT_EN.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 16  // legal 2..255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] d_i,
    output logic [3:0]         gnt,
    output logic [1:0]         sel,
    output logic               busy,
    output logic [WIDTH-1:0]   y
);

`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
    localparam logic [7:0] HOLD_SAT = 8'hFF;

    arb_state_t       state;
    logic [IDX_W-1:0] last_q;
    logic [7:0]       hold_cnt;
    logic [IDX_W-1:0] owner;

    logic             any_found;
    logic [IDX_W-1:0] any_idx;
    logic             oth_found;
    logic [IDX_W-1:0] oth_idx;
    logic             preempt;

    assign owner = onehot_to_idx(gnt);

    rr_pick u_pick_all (
        .req     (req),
        .last    (last_q),
        .mask    ('1),
        .found   (any_found),
        .win_idx (any_idx)
    );

    // Same search with the current owner masked out, for forced rotation.
    rr_pick u_pick_other (
        .req     (req),
        .last    (last_q),
        .mask    (~gnt),
        .found   (oth_found),
        .win_idx (oth_idx)
    );

    assign preempt = TIMEOUT_EN && (hold_cnt >= HOLD_LIM) && oth_found;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            last_q   <= '1;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_found) begin
                        state    <= GRANT;
                        gnt      <= NUM_REQ'(1) << any_idx;
                        sel      <= any_idx;
                        last_q   <= any_idx;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (preempt) begin
                        gnt      <= NUM_REQ'(1) << oth_idx;
                        sel      <= oth_idx;
                        last_q   <= oth_idx;
                        hold_cnt <= '0;
                    end else if (req[owner]) begin
                        if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 8'd1;
                    end else if (any_found) begin
                        gnt      <= NUM_REQ'(1) << any_idx;
                        sel      <= any_idx;
                        last_q   <= any_idx;
                        hold_cnt <= '0;
                    end else begin
                        state    <= IDLE;
                        gnt      <= '0;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    assign busy = |gnt;

    always_comb begin
        y = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (busy && (sel == IDX_W'(i))) y = d_i[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus randomized
// traffic compared against an integer-level round-robin reference model.
module tb_rr_mux_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         req;
    logic [4*WIDTH-1:0] d_i;
    logic [3:0]         gnt;
    logic [1:0]         sel;
    logic               busy;
    logic [WIDTH-1:0]   y;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 = nobody), last winner, hold count.
    int m_owner;
    int m_last;
    int m_hold;
    int m_sel;
    bit m_sel_known;

    rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .d_i   (d_i),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy),
        .y     (y)
    );

    always #5 clk = ~clk;

    function automatic int rr_search(input logic [3:0] r, input int last);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            idx = (last + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic take(input int w);
        m_owner     = w;
        m_last      = w;
        m_hold      = 0;
        m_sel       = w;
        m_sel_known = 1'b1;
    endtask

    task automatic model_edge();
        logic [3:0] others;
        int w;
        if (!rst_n) begin
            m_owner     = -1;
            m_last      = 3;
            m_hold      = 0;
            m_sel       = 0;
            m_sel_known = 1'b1;
        end else if (m_owner < 0) begin
            w = rr_search(req, m_last);
            if (w >= 0) take(w);
        end else begin
            others = req;
            others[m_owner] = 1'b0;
            if (TO_EN && m_hold >= MAX_HOLD - 1 && others != 4'b0000) begin
                take(rr_search(others, m_last));
            end else if (req[m_owner]) begin
                m_hold = (m_hold < 255) ? m_hold + 1 : 255;
            end else begin
                w = rr_search(req, m_last);
                if (w >= 0) take(w);
                else begin
                    m_owner     = -1;
                    m_hold      = 0;
                    m_sel_known = 1'b0;
                end
            end
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        logic [3:0]       eg;
        logic [WIDTH-1:0] ey;
        model_edge();
        @(posedge clk);
        #1;
        eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        ey = (m_owner < 0) ? '0 : d_i[m_owner*WIDTH +: WIDTH];
        checks++;
        if (gnt !== eg) begin
            errors++;
            $display("FAIL model_gnt: got %b expected %b at %0t", gnt, eg, $time);
        end
        checks++;
        if (busy !== (m_owner >= 0)) begin
            errors++;
            $display("FAIL model_busy: got %b expected %b at %0t", busy, (m_owner >= 0), $time);
        end
        checks++;
        if (y !== ey) begin
            errors++;
            $display("FAIL model_y: got %h expected %h at %0t", y, ey, $time);
        end
        if (m_sel_known) begin
            checks++;
            if (sel !== 2'(m_sel)) begin
                errors++;
                $display("FAIL model_sel: got %0d expected %0d at %0t", sel, m_sel, $time);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        d_i   = {$urandom, $urandom} & {4*WIDTH{1'b1}};
        for (int c = 0; c < 4; c++) begin
            if (c == 2) rst_n = 1'b1;
            step();
            checks++;
            if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || y !== '0) begin
                errors++;
                $display("FAIL reset_idle: got gnt=%b sel=%0d busy=%b y=%h expected all zero", gnt, sel, busy, y);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        d_i = '0;
        d_i[2*WIDTH +: WIDTH] = 8'hA5;
        req = 4'b0100;
        step();
        checks++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || y !== 8'hA5) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b sel=%0d y=%h expected 0100 2 a5", gnt, sel, y);
        end
        req = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b0000 || y !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got gnt=%b y=%h busy=%b expected 0000 00 0", gnt, y, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] prev;
        logic [3:0] seen[$];
        int         runs[$];
        int         held;
        int         prev_owner;
        logic [3:0] exp_order [5];
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        prev       = 4'b0000;
        held       = 0;
        prev_owner = -1;
        req        = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            step();
            if (gnt !== prev) begin
                seen.push_back(gnt);
                runs.push_back(1);
            end else begin
                runs[runs.size()-1]++;
            end
            prev = gnt;
            held = (m_owner == prev_owner) ? held + 1 : 1;
            prev_owner = m_owner;
            req = 4'b1111;
            if (held == 3 && m_owner >= 0) req[m_owner] = 1'b0;
        end
        checks++;
        if (seen.size() < 5) begin
            errors++;
            $display("FAIL b2b_count: got %0d grant changes expected at least 5", seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (seen[i] !== exp_order[i]) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got %b expected %b", i, seen[i], exp_order[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (runs[i] != 3) begin
                    errors++;
                    $display("FAIL b2b_len[%0d]: got %0d cycles expected 3", i, runs[i]);
                end
            end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b1001;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_first: got %b expected 0001", gnt);
        end
        req = 4'b1000;
        step();
        checks++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            errors++;
            $display("FAIL wrap_next: got gnt=%b sel=%0d expected 1000 3", gnt, sel);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 4'b0010;
        step();
        step();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_setup: got %b expected 0010", gnt);
        end
        req   = 4'b0011;
        rst_n = 1'b0;
        step();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_drop: got gnt=%b busy=%b expected 0000 0", gnt, busy);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_after: got %b expected 0001", gnt);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_timeout();
        logic [3:0] eg;
        do_reset();
        req = 4'b0101;
        for (int k = 0; k < 24; k++) begin
            step();
            if (TO_EN) eg = (((k / MAX_HOLD) % 2) == 0) ? 4'b0001 : 4'b0100;
            else       eg = 4'b0001;
            checks++;
            if (gnt !== eg) begin
                errors++;
                $display("FAIL timeout_k%0d: got %b expected %b", k, gnt, eg);
            end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) req = 4'($urandom);
            if ($urandom_range(0, 3) == 0) d_i = {$urandom, $urandom} & {4*WIDTH{1'b1}};
            rst_n = ($urandom_range(0, 59) != 0);
            step();
            checks++;
            if (!$onehot0(gnt)) begin
                errors++;
                $display("FAIL rand_onehot: got %b expected zero or one-hot", gnt);
            end
        end
        rst_n = 1'b1;
        req   = 4'b0000;
        step();
    endtask

    initial begin
        rst_n       = 1'b0;
        req         = 4'b0000;
        d_i         = '0;
        m_owner     = -1;
        m_last      = 3;
        m_hold      = 0;
        m_sel       = 0;
        m_sel_known = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Four-requester round-robin arbiter that shares one 4:1 WIDTH-bit mux between requesters.
- Registers the winning requester and drives the mux select from that register.
- Each requester owns the mux until it drops its request or, optionally, exhausts a hold budget.
- Sits between requester-side logic and the shared downstream datapath; replaces hand-driven select lines with a fair, sequenced grant.

Parameters:
- WIDTH, 8: bit width of each data input and of y.
- MAX_HOLD, 16: maximum consecutive grant cycles for one owner when another request is pending. Legal range 2..255. Active only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- req  input  4  request per requester; held high while access is wanted.
- d_i  input  4*WIDTH  packed data; requester k drives d_i[k*WIDTH +: WIDTH].
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- sel  output  2  encoded owner index, registered; drives the mux.
- busy  output  1  high when any grant is active (equals |gnt).
- y  output  WIDTH  d_i slice selected by sel when busy, else all-zero.

Behaviour:
- Reset: when rst_n=0 at a clk edge, the block sets:
  - gnt=0, sel=0, busy=0, y=0
  - state=IDLE
  - last=3, so requester 0 has top priority after reset
  - hold_cnt=0
- Round-robin order: search starts at (last+1) mod 4 and wraps, e.g. last=2 gives search order 3,0,1,2.
- States:
  - IDLE
  - GRANT
- IDLE:
  - If any req is set, the next edge moves to GRANT.
  - gnt becomes one-hot for the RR winner; sel, last and owner all take the winner index; hold_cnt=0.
  - Otherwise the block stays in IDLE.
- GRANT, req[owner]=1, no timeout: keep the current grant; hold_cnt increments and saturates at 255.
- GRANT, req[owner]=0 (release):
  - If any other req is set, the next edge grants the RR winner directly, with no idle bubble.
  - Otherwise the next edge returns to IDLE with gnt=0.
- Latency:
  - 1 cycle from req rising (in IDLE) to gnt.
  - 1 cycle from owner release to the next grant.
- Simultaneous events:
  - Multiple new requests: RR order decides.
  - A release coinciding with a new request from the same requester: that requester is still searched last.
- Data path: y is combinational from registered sel and busy plus live d_i. No added latency on data.
- Grant on a req that is already low never occurs: the winner is computed from current req.
- Reset mid-grant: the grant drops on the next edge regardless of req. After reset, requester 0 wins first.
- Invariants:
  - gnt is 0 or one-hot at all times.
  - sel equals the index of the set gnt bit.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - In GRANT, if hold_cnt==MAX_HOLD-1 and any non-owner req is set, the next edge force-rotates to the RR winner among non-owners, even if req[owner]=1.
  - The preempted owner keeps its request and competes normally.
  - If no other requester is pending, the owner keeps the grant and hold_cnt stays saturated.
- Undefined:
  - There is no preemption; the owner holds the grant until release.
  - hold_cnt logic may be removed entirely.

Decomposition:
- Package rr_arb_pkg:
  - constants NUM_REQ=4, IDX_W=2
  - enum arb_state_t {IDLE, GRANT}
  - function onehot_to_idx
- Sub-module rr_pick: combinational; inputs req[3:0], last[1:0], mask[3:0]; outputs found and win_idx[1:0].
  - Used for both normal and timeout (owner-masked) selection.
- The FSM, registers and output mux live in rr_mux_arbiter.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, req=0 → gnt=0, sel=0, busy=0, y=0 on every cycle.
- Single requester, WIDTH=8, d_i slice 2 = 8'hA5: req=4'b0100 → next cycle gnt=4'b0100, sel=2, y=8'hA5; drop req → next cycle gnt=0, y=0.
- All four request and each releases after 3 cycles: req=4'b1111 from reset → grant order 0,1,2,3,0. No idle cycle between owners; each grant lasts 3 cycles.
- Fairness wrap: last=3, req=4'b1001 → requester 0 granted. After its release with req3 still high → requester 3 granted the next cycle.
- Mid-grant reset: requester 1 holds a grant, rst_n=0 for 1 cycle, req=4'b0011 held → gnt=0 during reset, then gnt=4'b0001 (requester 0 wins).
- ARB_TIMEOUT_EN, MAX_HOLD=4: req0 and req2 held high continuously → gnt alternates 0,2,0,2 with exactly 4 cycles each. Without the macro, requester 0 holds the grant indefinitely.
